// File: rtl/afe_l2_pkg.sv
// Shared types and lane-placement helpers for the AFE L2 write controller.
package afe_l2_pkg;

   localparam int L2_DW = 32;

   typedef enum logic [1:0] {
      DS_8B  = 2'b00,
      DS_16B = 2'b01,
      DS_32B = 2'b10
   } datasize_e;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   // Data size encoding 2'b11 behaves like 32b, hence the default arm.
   function automatic logic [3:0] calc_be(input logic [1:0] ds, input logic [1:0] a);
      logic [3:0] be;
      case (ds)
         DS_8B:   be = 4'b0001 << a;
         DS_16B:  be = 4'b0011 << {a[1], 1'b0};
         default: be = 4'hF;
      endcase
      return be;
   endfunction

   function automatic logic [L2_DW-1:0] calc_wdata(input logic [1:0] ds, input logic [L2_DW-1:0] d);
      logic [L2_DW-1:0] w;
      case (ds)
         DS_8B:   w = {4{d[7:0]}};
         DS_16B:  w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/afe_l2_wr_fifo.sv
// Sample buffer for the AFE L2 write controller: DEPTH x WIDTH ring buffer
// with synchronous flush and an occupancy count.
module afe_l2_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             test_mode,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             unused_test_mode;

   // No clock gating is implemented here, so the DFT input has no effect.
   assign unused_test_mode = test_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/afe_l2_wr_ctrl.sv
// AFE L2 write controller: buffers samples and issues one lane-placed L2 write
// per sample. Define AFE_L2_WR_DROP_EN to discard samples on overflow instead of backpressuring.
module afe_l2_wr_ctrl
   import afe_l2_pkg::*;
#(
   parameter int AWIDTH     = 18,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  test_mode_i,
   input  logic                  cfg_en_i,
   input  logic [1:0]            cfg_datasize_i,
   input  logic [AWIDTH-1:0]     cfg_curr_addr_i,
   input  logic                  data_valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  data_ready_o,
   output logic                  l2_req_o,
   input  logic                  l2_gnt_i,
   output logic [AWIDTH-1:0]     l2_addr_o,
   output logic                  l2_we_o,
   output logic [3:0]            l2_be_o,
   output logic [DATA_WIDTH-1:0] l2_wdata_o,
   output logic                  transfer_valid_o,
   output logic [7:0]            drop_cnt_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e                state;
   state_e                next_state;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic                  full;
   logic                  empty;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] head;

   afe_l2_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .test_mode (test_mode_i),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .wdata     (data_i),
      .rdata     (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign pop   = l2_req_o & l2_gnt_i;
   assign flush = (state == IDLE) & ~cfg_en_i;

`ifdef AFE_L2_WR_DROP_EN
   logic       cfg_en_q;
   logic       drop;
   logic [7:0] drop_cnt;

   assign data_ready_o = cfg_en_i;
   assign push         = data_valid_i & cfg_en_i & ~full;
   assign drop         = data_valid_i & cfg_en_i & full;
   assign drop_cnt_o   = drop_cnt;

   // A fresh enable starts a new drop-count window; the clear wins over a same-cycle drop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_en_q <= 1'b0;
         drop_cnt <= '0;
      end else begin
         cfg_en_q <= cfg_en_i;
         if (cfg_en_i && !cfg_en_q)
            drop_cnt <= '0;
         else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end
`else
   assign data_ready_o = cfg_en_i & ~full;
   assign push         = data_valid_i & data_ready_o;
   assign drop_cnt_o   = '0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= next_state;
   end

   // Back-to-back writes continue only while more data is buffered or arriving.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (!empty && cfg_en_i) next_state = REQ;
         REQ:  if (l2_gnt_i)
                  next_state = ((count > CW'(1) || push) && cfg_en_i) ? REQ : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      l2_req_o = 1'b0;
      case (state)
         REQ:     l2_req_o = 1'b1;
         default: l2_req_o = 1'b0;
      endcase
   end

   assign transfer_valid_o = l2_req_o & l2_gnt_i;
   assign l2_we_o          = 1'b1;
   assign l2_addr_o        = {cfg_curr_addr_i[AWIDTH-1:2], 2'b00};
   assign l2_be_o          = calc_be(cfg_datasize_i, cfg_curr_addr_i[1:0]);
   assign l2_wdata_o       = calc_wdata(cfg_datasize_i, head);

endmodule

// File: tb/tb_afe_l2_wr_ctrl.sv
// Self-checking bench for afe_l2_wr_ctrl: directed scenarios plus a randomized
// phase, all checked against a queue-based reference of expected L2 writes.
module tb_afe_l2_wr_ctrl;

   localparam int DEPTH = 4;

   typedef struct {
      logic [17:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } wr_t;

   logic        clk_i;
   logic        rst_ni;
   logic        test_mode_i;
   logic        cfg_en_i;
   logic [1:0]  cfg_datasize_i;
   logic [17:0] cfg_curr_addr_i;
   logic        data_valid_i;
   logic [31:0] data_i;
   logic        data_ready_o;
   logic        l2_req_o;
   logic        l2_gnt_i;
   logic [17:0] l2_addr_o;
   logic        l2_we_o;
   logic [3:0]  l2_be_o;
   logic [31:0] l2_wdata_o;
   logic        transfer_valid_o;
   logic [7:0]  drop_cnt_o;

   wr_t         q[$];
   int          checks;
   int          errors;
   int          cyc;
   int          pulses;
   int          first_req;
   int          mdrop;
   int          c0;
   int          p0;
   int          sent;
   logic        prev_en;
   logic        prev_req_wait;
   logic        accepted;
   logic        saw_not_ready;
   logic [3:0]  cap_be;
   logic [31:0] cap_wdata;
   logic [17:0] cap_addr;

   afe_l2_wr_ctrl dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .test_mode_i      (test_mode_i),
      .cfg_en_i         (cfg_en_i),
      .cfg_datasize_i   (cfg_datasize_i),
      .cfg_curr_addr_i  (cfg_curr_addr_i),
      .data_valid_i     (data_valid_i),
      .data_i           (data_i),
      .data_ready_o     (data_ready_o),
      .l2_req_o         (l2_req_o),
      .l2_gnt_i         (l2_gnt_i),
      .l2_addr_o        (l2_addr_o),
      .l2_we_o          (l2_we_o),
      .l2_be_o          (l2_be_o),
      .l2_wdata_o       (l2_wdata_o),
      .transfer_valid_o (transfer_valid_o),
      .drop_cnt_o       (drop_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference write for a sample: access width in bytes decides lane group and replication.
   function automatic wr_t ref_write(input logic [1:0] ds, input logic [17:0] addr, input logic [31:0] d);
      wr_t w;
      int  n;
      int  a;
      n = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
      a = int'(addr[1:0]);
      w.addr = addr & 18'h3FFFC;
      w.be   = 4'(((1 << n) - 1) << ((a / n) * n));
      for (int i = 0; i < 4; i++) w.wdata[8*i +: 8] = d[8*(i % n) +: 8];
      return w;
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      q.delete();
      mdrop         = 0;
      prev_en       = 1'b0;
      prev_req_wait = 1'b0;
   endtask

   // Called once per cycle mid-period: compare, then advance the model across the next edge.
   task automatic checkOutput();
      logic full_before;
      logic exp_ready;
      logic en_rise;
      full_before = (q.size() >= DEPTH);
`ifdef AFE_L2_WR_DROP_EN
      exp_ready = cfg_en_i;
`else
      exp_ready = cfg_en_i && !full_before;
`endif
      checkValue("data_ready", 32'(data_ready_o), 32'(exp_ready));
      checkValue("drop_cnt", 32'(drop_cnt_o), 32'(mdrop));
      checkValue("transfer_valid", 32'(transfer_valid_o), 32'(l2_req_o & l2_gnt_i));
      if (prev_req_wait) checkValue("req_held", 32'(l2_req_o), 32'd1);
      if (l2_req_o) begin
         checkValue("req_has_data", 32'(q.size() > 0), 32'd1);
         checkValue("we", 32'(l2_we_o), 32'd1);
         if (q.size() > 0) begin
            checkValue("addr", 32'(l2_addr_o), 32'(q[0].addr));
            checkValue("be", 32'(l2_be_o), 32'(q[0].be));
            checkValue("wdata", l2_wdata_o, q[0].wdata);
         end
         if (first_req < 0) begin
            first_req = cyc;
            cap_addr  = l2_addr_o;
            cap_be    = l2_be_o;
            cap_wdata = l2_wdata_o;
         end
      end
      if (!data_ready_o) saw_not_ready = 1'b1;
      if (transfer_valid_o) begin
         pulses++;
         if (q.size() > 0) void'(q.pop_front());
      end
      prev_req_wait = l2_req_o && !l2_gnt_i;
      accepted      = data_valid_i && exp_ready;
      en_rise       = cfg_en_i && !prev_en;
      if (en_rise) mdrop = 0;
      if (accepted) begin
         if (!full_before)
            q.push_back(ref_write(cfg_datasize_i, cfg_curr_addr_i, data_i));
         else if (!en_rise && mdrop < 255)
            mdrop++;
      end
      prev_en = cfg_en_i;
      if (!cfg_en_i && !l2_req_o) q.delete();
      cyc++;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic g);
      data_valid_i = v;
      data_i       = d;
      l2_gnt_i     = g;
      @(negedge clk_i);
      checkOutput();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; pulses = 0; first_req = -1;
      saw_not_ready = 1'b0;
      test_mode_i = 1'b0; cfg_en_i = 1'b0; cfg_datasize_i = 2'b10; cfg_curr_addr_i = '0;
      data_valid_i = 1'b0; data_i = '0; l2_gnt_i = 1'b0;
      resetModel();
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      @(posedge clk_i); #1;
      checkValue("reset_req", 32'(l2_req_o), 32'd0);
      checkValue("reset_tv", 32'(transfer_valid_o), 32'd0);
      checkValue("reset_drop", 32'(drop_cnt_o), 32'd0);
      checkValue("reset_ready", 32'(data_ready_o), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      $display("[TB] T1 32b back-to-back writes");
      cfg_en_i = 1'b1; cfg_datasize_i = 2'b10; cfg_curr_addr_i = 18'h100;
      applyStimulus(1'b0, 32'h0, 1'b1);
      c0 = cyc; p0 = pulses; first_req = -1;
      applyStimulus(1'b1, 32'hA5A5_0001, 1'b1);
      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      applyStimulus(1'b1, 32'h0000_0003, 1'b1);
      drain(5);
      checkValue("t1_first_req_latency", 32'(first_req - c0), 32'd2);
      checkValue("t1_pulses", 32'(pulses - p0), 32'd3);
      checkValue("t1_be", 32'(cap_be), 32'hF);
      checkValue("t1_wdata", cap_wdata, 32'hA5A5_0001);

      $display("[TB] T2 8b write at byte 3");
      cfg_datasize_i = 2'b00; cfg_curr_addr_i = 18'h103; first_req = -1;
      applyStimulus(1'b1, 32'h0000_007E, 1'b1);
      drain(4);
      checkValue("t2_addr", 32'(cap_addr), 32'h100);
      checkValue("t2_be", 32'(cap_be), 32'b1000);
      checkValue("t2_wdata", cap_wdata, 32'h7E7E_7E7E);

      $display("[TB] T3 16b with grant held off");
      cfg_datasize_i = 2'b01; cfg_curr_addr_i = 18'h2A2;
      p0 = pulses; sent = 0; saw_not_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         applyStimulus(sent < 6, 32'h1000 + sent, i >= 5);
         if (accepted) sent++;
      end
      drain(6);
`ifdef AFE_L2_WR_DROP_EN
      checkValue("t3_pulses", 32'(pulses - p0), 32'd4);
`else
      checkValue("t3_saw_backpressure", 32'(saw_not_ready), 32'd1);
      checkValue("t3_pulses", 32'(pulses - p0), 32'd6);
`endif

      $display("[TB] T4 enable drops during request");
      cfg_datasize_i = 2'b10; cfg_curr_addr_i = 18'h040;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC0DE_0000 + i, 1'b0);
      for (int i = 0; i < 5 && !l2_req_o; i++) applyStimulus(1'b0, 32'h0, 1'b0);
      checkValue("t4_req_up", 32'(l2_req_o), 32'd1);
      cfg_en_i = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      p0 = pulses;
      drain(5);
      checkValue("t4_one_write", 32'(pulses - p0), 32'd1);
      cfg_en_i = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkValue("t4_no_req", 32'(l2_req_o), 32'd0);
         applyStimulus(1'b0, 32'h0, 1'b1);
      end
      checkValue("t4_no_more_writes", 32'(pulses - p0), 32'd1);

`ifdef AFE_L2_WR_DROP_EN
      $display("[TB] T5 drop counter saturation");
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 32'(i), 1'b0);
      checkValue("t5_drop_sat", 32'(drop_cnt_o), 32'hFF);
      cfg_en_i = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      cfg_en_i = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkValue("t5_drop_clear", 32'(drop_cnt_o), 32'h0);
      drain(8);
`endif

      $display("[TB] T6 asynchronous reset mid-request");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hBEEF_0000 + i, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkValue("t6_req_before", 32'(l2_req_o), 32'd1);
      #2;
      rst_ni = 1'b0;
      l2_gnt_i = 1'b1;
      #1;
      checkValue("t6_req", 32'(l2_req_o), 32'd0);
      checkValue("t6_tv", 32'(transfer_valid_o), 32'd0);
      checkValue("t6_ready", 32'(data_ready_o), 32'd1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      resetModel();
      p0 = pulses;
      drain(4);
      checkValue("t6_no_writes", 32'(pulses - p0), 32'd0);

      $display("[TB] random phase");
      for (int i = 0; i < 500; i++) begin
         if (q.size() == 0 && !l2_req_o && $urandom_range(0, 3) == 0) begin
            cfg_datasize_i  = 2'($urandom_range(0, 3));
            cfg_curr_addr_i = 18'($urandom);
         end
         cfg_en_i = ($urandom_range(0, 19) != 0);
         applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2) != 0);
      end
      cfg_en_i = 1'b1;
      drain(10);
      checkValue("final_no_req", 32'(l2_req_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
